// File: rtl/paridad_serie_if.sv
// Bundle for the parity serialiser: parallel TX word handshake, serial TX/RX
// bit streams and the received-word report.
interface paridad_serie_if #(
  parameter int DATA_W = 7,
  parameter int CNT_W  = 8
);
  logic [DATA_W-1:0] data_in;
  logic              parimpar;
  logic              in_valid;
  logic              in_ready;
  logic              tx_bit;
  logic              tx_valid;
  logic              rx_bit;
  logic              rx_valid;
  logic              rx_parimpar;
  logic [DATA_W-1:0] data_out;
  logic              out_valid;
  logic              par_err;
  logic [CNT_W-1:0]  err_cnt;

  modport master (
    output data_in, parimpar, in_valid, rx_bit, rx_valid, rx_parimpar,
    input  in_ready, tx_bit, tx_valid, data_out, out_valid, par_err, err_cnt
  );

  modport slave (
    input  data_in, parimpar, in_valid, rx_bit, rx_valid, rx_parimpar,
    output in_ready, tx_bit, tx_valid, data_out, out_valid, par_err, err_cnt
  );
endinterface

// File: rtl/paridad_serie.sv
// Serial parity link: TX serialises a word LSB-first plus a parity bit,
// RX deserialises, rechecks parity and keeps a saturating error count.
module paridad_serie #(
  parameter int DATA_W = 7,
  parameter int CNT_W  = 8
) (
  input logic             clk,
  input logic             reset,
  paridad_serie_if.slave  bus
);
  localparam int BW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, PAR} tx_state_e;

  tx_state_e         state, state_d;
  logic [DATA_W-1:0] shreg;
  logic              paridad;
  logic [BW-1:0]     bcnt;
  logic              accept;
  logic              ready_d, txv_d, txb_d;

  assign accept = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      bus.in_ready <= 1'b0;
      bus.tx_valid <= 1'b0;
      bus.tx_bit   <= 1'b0;
      shreg        <= '0;
      paridad      <= 1'b0;
      bcnt         <= '0;
    end else begin
      state        <= state_d;
      bus.in_ready <= ready_d;
      bus.tx_valid <= txv_d;
      bus.tx_bit   <= txb_d;
      if (accept) begin
        shreg   <= bus.data_in;
        paridad <= (^bus.data_in) ^ bus.parimpar;
        bcnt    <= '0;
      end else if (state == SHIFT) begin
        shreg <= {1'b0, shreg[DATA_W-1:1]};
        bcnt  <= bcnt + BW'(1);
      end
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (bcnt == BW'(DATA_W - 1)) state_d = PAR;
      PAR:     state_d = accept ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so decode them from the state being entered.
  always_comb begin
    ready_d = (state_d != SHIFT);
    txv_d   = (state_d != IDLE);
    txb_d   = 1'b0;
    unique case (state_d)
      SHIFT:   txb_d = accept ? bus.data_in[0] : shreg[1];
      PAR:     txb_d = paridad;
      default: txb_d = 1'b0;
    endcase
  end

  logic [BW-1:0]     rcnt;
  logic [DATA_W-1:0] rreg;
  logic              mism;

  assign mism = bus.rx_bit ^ (^rreg) ^ bus.rx_parimpar;

  always_ff @(posedge clk) begin
    if (reset) begin
      rcnt          <= '0;
      rreg          <= '0;
      bus.data_out  <= '0;
      bus.out_valid <= 1'b0;
      bus.par_err   <= 1'b0;
      bus.err_cnt   <= '0;
    end else begin
      bus.out_valid <= 1'b0;
      bus.par_err   <= 1'b0;
      if (bus.rx_valid) begin
        if (rcnt == BW'(DATA_W)) begin
          bus.data_out  <= rreg;
          bus.out_valid <= 1'b1;
          bus.par_err   <= mism;
          if (mism && (bus.err_cnt != {CNT_W{1'b1}}))
            bus.err_cnt <= bus.err_cnt + CNT_W'(1);
          rcnt <= '0;
        end else begin
          rreg <= {bus.rx_bit, rreg[DATA_W-1:1]};
          rcnt <= rcnt + BW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_paridad_serie.sv
// Scoreboard bench for paridad_serie: directed TX words, loopback, RX parity
// errors with gaps, counter saturation and mid-word reset.
module tb_paridad_serie;
  localparam int DW = 7;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  paridad_serie_if #(.DATA_W(DW), .CNT_W(8)) dif ();
  paridad_serie_if #(.DATA_W(DW), .CNT_W(2)) sif ();

  paridad_serie #(.DATA_W(DW), .CNT_W(8)) u_dut (.clk(clk), .reset(reset), .bus(dif.slave));
  paridad_serie #(.DATA_W(DW), .CNT_W(2)) u_sat (.clk(clk), .reset(reset), .bus(sif.slave));

  logic [DW-1:0] din;
  logic          pm, iv, rxb, rxv, rxm, loop, sat_en;

  assign dif.data_in     = din;
  assign dif.parimpar    = pm;
  assign dif.in_valid    = iv;
  assign dif.rx_bit      = loop ? dif.tx_bit : rxb;
  assign dif.rx_valid    = loop ? dif.tx_valid : (rxv & ~sat_en);
  assign dif.rx_parimpar = rxm;
  assign sif.data_in     = '0;
  assign sif.parimpar    = 1'b0;
  assign sif.in_valid    = 1'b0;
  assign sif.rx_bit      = rxb;
  assign sif.rx_valid    = rxv & sat_en;
  assign sif.rx_parimpar = rxm;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          pe;
    logic [7:0]    cnt;
  } rx_exp_t;

  int      checks = 0;
  int      failures = 0;
  logic    tx_q[$];
  rx_exp_t rx_q[$];
  rx_exp_t sat_q[$];
  int      run = 0;
  int      max_run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : mon_tx
    logic e;
    if (dif.tx_valid === 1'b1) begin
      run++;
      if (run > max_run) max_run = run;
      if (tx_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL tx_unexpected actual tx_bit=%0b required no tx_valid", dif.tx_bit);
      end else begin
        e = tx_q.pop_front();
        chk("tx_bit", 32'(dif.tx_bit), 32'(e));
      end
    end else begin
      run = 0;
    end
  end

  always @(negedge clk) begin : mon_rx
    rx_exp_t e;
    if (dif.out_valid === 1'b1) begin
      if (rx_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rx_unexpected actual data_out=%0h required no out_valid", dif.data_out);
      end else begin
        e = rx_q.pop_front();
        chk("rx_data", 32'(dif.data_out), 32'(e.d));
        chk("rx_par_err", 32'(dif.par_err), 32'(e.pe));
        chk("rx_err_cnt", 32'(dif.err_cnt), 32'(e.cnt));
      end
    end
  end

  always @(negedge clk) begin : mon_sat
    rx_exp_t e;
    if (sif.out_valid === 1'b1) begin
      if (sat_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sat_unexpected actual data_out=%0h required no out_valid", sif.data_out);
      end else begin
        e = sat_q.pop_front();
        chk("sat_par_err", 32'(sif.par_err), 32'(e.pe));
        chk("sat_err_cnt", 32'(sif.err_cnt), 32'(e.cnt));
      end
    end
  end

  task automatic push_tx(input logic [DW-1:0] w, input logic p);
    for (int i = 0; i < DW; i++) tx_q.push_back(w[i]);
    tx_q.push_back(p);
  endtask

  task automatic send_tx(input logic [DW-1:0] w, input logic m, input logic p);
    int n = 0;
    while (dif.in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout actual=0 required=1");
    end
    din = w;
    pm  = m;
    iv  = 1'b1;
    push_tx(w, p);
    tick();
    iv = 1'b0;
  endtask

  task automatic rx_word(input logic [DW-1:0] w, input logic p, input logic m,
                         input bit gaps, input bit to_sat, input logic pe, input logic [7:0] cnt);
    rx_exp_t e;
    e = '{d: w, pe: pe, cnt: cnt};
    if (to_sat) sat_q.push_back(e);
    else rx_q.push_back(e);
    for (int i = 0; i <= DW; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          rxv = 1'b0;
          tick();
        end
      end
      rxb = (i < DW) ? w[i] : p;
      rxm = m;
      rxv = 1'b1;
      tick();
    end
    rxv = 1'b0;
  endtask

  logic [DW-1:0] tw [5] = '{7'b1000101, 7'b1000101, 7'b1100110, 7'b1100110, 7'b1111111};
  logic          tm [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic          tp [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  logic [DW-1:0] lw [3] = '{7'b1000101, 7'b1100110, 7'b1111111};
  logic          lm [3] = '{1'b0, 1'b1, 1'b0};
  logic          lp [3] = '{1'b1, 1'b1, 1'b1};

  logic [DW-1:0] bad_w;
  logic [7:0]    sat_exp [5] = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3};

  initial begin
    din = '0; pm = 1'b0; iv = 1'b0; rxb = 1'b0; rxv = 1'b0; rxm = 1'b0;
    loop = 1'b0; sat_en = 1'b0;
    bad_w = 7'b1100110;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(dif.in_ready), 32'd0);
    chk("rst_tx_valid", 32'(dif.tx_valid), 32'd0);
    chk("rst_tx_bit", 32'(dif.tx_bit), 32'd0);
    chk("rst_data_out", 32'(dif.data_out), 32'd0);
    chk("rst_out_valid", 32'(dif.out_valid), 32'd0);
    chk("rst_par_err", 32'(dif.par_err), 32'd0);
    chk("rst_err_cnt", 32'(dif.err_cnt), 32'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_in_ready", 32'(dif.in_ready), 32'd1);

    for (int i = 0; i < 5; i++) begin
      send_tx(tw[i], tm[i], tp[i]);
      repeat (10) tick();
    end

    // Back-to-back loopback; rx_parimpar follows the word whose parity is next.
    max_run = 0;
    loop = 1'b1;
    for (int n = 0; n < 3; n++) begin
      push_tx(lw[n], lp[n]);
      rx_q.push_back('{d: lw[n], pe: 1'b0, cnt: 8'd0});
    end
    din = lw[0]; pm = lm[0]; iv = 1'b1; rxm = lm[0];
    for (int n = 0; n < 3; n++) begin
      @(posedge clk);
      #1;
      if (n < 2) begin
        din = lw[n+1];
        pm  = lm[n+1];
      end else begin
        iv = 1'b0;
      end
      tick();
      rxm = lm[n];
      repeat (6) tick();
    end
    repeat (12) tick();
    chk("loop_tx_valid_run", 32'(max_run), 32'd24);
    loop = 1'b0;

    rx_word(7'b1100110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1);
    repeat (3) tick();
    rx_word(7'b1100110, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd2);
    rx_word(7'b1000101, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2);
    rx_word(7'b1111111, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd3);
    repeat (3) tick();

    sat_en = 1'b1;
    for (int i = 0; i < 5; i++) rx_word(bad_w, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, sat_exp[i]);
    repeat (3) tick();
    sat_en = 1'b0;

    // Reset lands while TX shows bit 3 and RX presents bit 4.
    din = 7'b1000101; pm = 1'b0; iv = 1'b1;
    push_tx(7'b1000101, 1'b1);
    rxb = bad_w[0]; rxm = 1'b0; rxv = 1'b1;
    tick();
    iv = 1'b0; rxb = bad_w[1];
    tick();
    rxb = bad_w[2];
    tick();
    rxb = bad_w[3];
    tick();
    rxb = bad_w[4];
    reset = 1'b1;
    tick();
    tx_q.delete();
    rxv = 1'b0;
    chk("mid_rst_in_ready", 32'(dif.in_ready), 32'd0);
    chk("mid_rst_tx_valid", 32'(dif.tx_valid), 32'd0);
    chk("mid_rst_tx_bit", 32'(dif.tx_bit), 32'd0);
    chk("mid_rst_data_out", 32'(dif.data_out), 32'd0);
    chk("mid_rst_out_valid", 32'(dif.out_valid), 32'd0);
    chk("mid_rst_err_cnt", 32'(dif.err_cnt), 32'd0);
    chk("mid_rst_sat_cnt", 32'(sif.err_cnt), 32'd0);
    reset = 1'b0;
    tick();
    chk("mid_rst_ready_back", 32'(dif.in_ready), 32'd1);

    loop = 1'b1;
    rxm = 1'b1;
    rx_q.push_back('{d: 7'b1100110, pe: 1'b0, cnt: 8'd0});
    send_tx(7'b1100110, 1'b1, 1'b1);
    repeat (12) tick();
    loop = 1'b0;

    for (int n = 0; n < 50 && (tx_q.size() + rx_q.size() + sat_q.size()) != 0; n++) tick();
    chk("queues_drained", 32'(tx_q.size() + rx_q.size() + sat_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/paridad_serie.md
# paridad_serie

Parametrised serial parity transmitter/checker: the sequential successor to the 7-bit combinational even/odd parity generator. The TX path accepts a DATA_W-bit word over a valid/ready handshake and serialises it LSB-first, followed by one parity bit. The RX path deserialises an incoming bit stream, recomputes parity, flags mismatches and counts them. It sits between the parallel data source and the serial link, and both paths can be looped back for self-test.

## Interface
Parameters:
- DATA_W, 7, payload bits per word (≥2)
- CNT_W, 8, width of the saturating error counter

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- data_in  in  DATA_W  TX word
- parimpar  in  1  TX mode, sampled at accept: 0 = even parity, 1 = odd parity
- in_valid  in  1  TX word offered
- in_ready  out  1  TX can accept
- tx_bit  out  1  serial data out
- tx_valid  out  1  tx_bit qualifier
- rx_bit  in  1  serial data in
- rx_valid  in  1  rx_bit qualifier
- rx_parimpar  in  1  RX mode, sampled with the parity bit: 0 = even, 1 = odd
- data_out  out  DATA_W  last received word
- out_valid  out  1  one-cycle strobe, word complete
- par_err  out  1  parity mismatch for the word in data_out; valid while out_valid = 1
- err_cnt  out  CNT_W  count of mismatched words, saturating

## Operation
- Parity definition:
  - Even mode: paridad = ^word, so the total count of 1s including the parity bit is even.
  - Odd mode: paridad = ~^word.
- TX FSM states: IDLE, SHIFT, PAR.
  - IDLE: in_ready = 1 and tx_valid = 0. When in_valid & in_ready, latch data_in into the shift register, latch parimpar, compute paridad, clear the bit counter, and go to SHIFT.
  - SHIFT: tx_valid = 1 and tx_bit = shreg[0]. Shift right each cycle. After DATA_W cycles, go to PAR.
  - PAR: tx_valid = 1, tx_bit = latched paridad, in_ready = 1.
    - If in_valid in PAR, accept the new word and go directly to SHIFT (back-to-back, no gap).
    - Otherwise go to IDLE.
- in_ready is 0 throughout SHIFT.
- in_valid while in_ready = 0 is ignored. The source must hold the word until accepted.
- RX path:
  - Bit counter 0..DATA_W advances only on cycles with rx_valid = 1. Gaps of any length are allowed and hold state.
  - Counts 0..DATA_W-1: bit is shifted into the receive register LSB-first.
  - Count DATA_W: the bit is the received parity. Compare it with the parity recomputed from the received word using rx_parimpar. Next cycle:
    - data_out = word
    - out_valid = 1 for exactly one cycle
    - par_err = mismatch
    - err_cnt += mismatch
  - The counter then returns to 0, and the next valid bit starts a new word in the same cycle.
- err_cnt saturates at 2^CNT_W−1 and never wraps. It is cleared only by reset.
- data_out holds its value until the next word completes. par_err is 0 whenever out_valid = 0.

## Timing
- All outputs are registered.
- Reset values: in_ready = 0 during reset, 1 the cycle after reset deasserts. tx_bit = 0, tx_valid = 0, data_out = 0, out_valid = 0, par_err = 0, err_cnt = 0. TX FSM = IDLE, RX counter = 0.
- Reset mid-word (either path): the word is discarded, no out_valid is produced, and err_cnt is cleared.
- TX latency: for a word accepted at edge k:
  - tx_valid = 1 for cycles k+1 .. k+DATA_W+1
  - data bit i appears in cycle k+1+i
  - parity appears in cycle k+DATA_W+1
- TX throughput: one word per DATA_W+1 cycles when in_valid is held high.
- RX latency: out_valid rises one cycle after the edge that samples the parity bit.
- Simultaneous events: the RX path is independent of the TX path. A TX accept in PAR and an RX word completion in the same cycle are both honoured.
- Loopback: connecting tx_bit/tx_valid to rx_bit/rx_valid with matching modes yields out_valid DATA_W+2 cycles after accept, with par_err = 0.

## Test plan
All scenarios use DATA_W = 7.
- Even mode, data_in = 1000101 (three 1s) -> tx sequence 1,0,1,0,0,0,1 then parity 1. Odd mode, same word -> parity 0.
- Even mode, data_in = 1100110 -> parity 0. Odd mode -> parity 1. Odd mode, 1111111 -> parity 0.
- Loopback with in_valid held high for 3 words (1000101, 1100110, 1111111), mixed modes, rx_parimpar matched per word:
  - tx_valid stays high continuously for 24 cycles
  - 3 out_valid strobes
  - data_out matches each word
  - par_err = 0 and err_cnt = 0
- RX stimulus 1100110 + parity 1 with rx_parimpar = 0 -> out_valid with par_err = 1 and err_cnt = 1. Insert random rx_valid gaps and confirm the result is identical.
- CNT_W = 2, five bad words -> err_cnt = 1, 2, 3, 3, 3 (saturates).
- Assert reset during TX bit 3 and RX bit 4 -> the next cycle shows all outputs at reset values. A fresh word afterwards transmits and checks correctly, with no stale out_valid.
